seven_seg_scanner: RTL and testbench

//  Downstream display stage for the game controller. Takes the four 7-segment glyph patterns
//  it drives (room/sword/win/dEAd) and time-multiplexes them onto one common-anode 4-digit display.

---
 rtl/seven_seg_scanner_pkg.sv | 29 ++
 rtl/seven_seg_scanner_if.sv | 34 +++
 rtl/seven_seg_scanner_timer.sv | 57 +++++
 rtl/seven_seg_scanner.sv | 104 ++++++++++
 tb/tb_seven_seg_scanner.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/seven_seg_scanner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_pkg
//  Description : Shared types, glyph constants and anode helper for the
//                four-digit seven-segment scanner.
//  Revision    : 1.0  initial release
// ============================================================================
package seven_seg_pkg;

    typedef logic [6:0] seg_t;   // bit[6]=a ... bit[0]=g
    typedef logic [1:0] dsel_t;  // digit index, 3 = leftmost

    localparam seg_t SEG_BLANK = 7'h00;
    localparam seg_t SEG_ALL   = 7'h7F;

    localparam seg_t GLYPH_D   = 7'b0111101;
    localparam seg_t GLYPH_E   = 7'b1001111;
    localparam seg_t GLYPH_A   = 7'b1110111;

    localparam logic [3:0] AN_OFF  = 4'hF;
    localparam seg_t       SEG_OFF = 7'h7F;

    // Active-low anode pattern enabling only the selected digit.
    function automatic logic [3:0] an_select(input dsel_t sel);
        return ~(4'b0001 << sel);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_if
//  Description : Glyph input / display drive bundle between the game
//                controller (master) and the display scanner (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface seven_seg_if;
    import seven_seg_pkg::*;

    seg_t [3:0] digits;      // active-high glyphs, [3] leftmost
    logic       blink;       // blink request
    logic [3:0] an;          // active-low anode enables
    seg_t       seg;         // active-low cathodes
    logic       frame_tick;  // pulse when the snapshot loads

    modport master (
        output digits,
        output blink,
        input  an,
        input  seg,
        input  frame_tick
    );

    modport slave (
        input  digits,
        input  blink,
        output an,
        output seg,
        output frame_tick
    );

endinterface
`default_nettype wire

// File: rtl/seven_seg_scanner_timer.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_timer
//  Description : Slot timer for the scanner. Counts cycles within a digit
//                slot and steps the digit select 3->2->1->0->3 on each wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module seg_scan_timer
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 8
) (
    input  wire logic clk,
    input  wire logic reset_n,
    output dsel_t     o_sel,
    output logic      o_slot_end,
    output logic      o_frame_end,
    output logic      o_in_blank
);

    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] r_cnt;
    dsel_t         r_sel;
    logic          w_slot_end;

    assign w_slot_end = (r_cnt == CW'(REFRESH_DIV - 1));

    // Slot counter and digit select; select decrements and wraps 0 -> 3.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_sel <= 2'd3;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_sel <= r_sel - 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A zero-length blank window would make the compare constant-false.
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign o_in_blank = 1'b0;
        end else begin : g_blank
            assign o_in_blank = (r_cnt < CW'(BLANK_CYC));
        end
    endgenerate

    assign o_sel       = r_sel;
    assign o_slot_end  = w_slot_end;
    assign o_frame_end = w_slot_end & (r_sel == 2'd0);

endmodule
`default_nettype wire

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scanner
//  Description : Time-multiplexes four captured glyphs onto a common-anode
//                4-digit display with per-slot anti-ghost blanking.
//                Optional blinking is compiled in with SEVSEG_BLINK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYC    = 8,
    parameter int BLINK_FRAMES = 64
) (
    input  wire logic  clk,
    input  wire logic  reset_n,
    seven_seg_if.slave bus
);

    dsel_t      w_sel;
    logic       w_slot_end;
    logic       w_frame_end;
    logic       w_in_blank;
    logic       w_blink_off;
    logic       w_off;

    seg_t [3:0] r_snap;
    logic [3:0] r_an;
    seg_t       r_seg;
    logic       r_frame_tick;

    seg_scan_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYC   (BLANK_CYC)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .o_sel       (w_sel),
        .o_slot_end  (w_slot_end),
        .o_frame_end (w_frame_end),
        .o_in_blank  (w_in_blank)
    );

`ifdef SEVSEG_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic PHASE_ON  = 1'b0;
    localparam logic PHASE_OFF = 1'b1;

    logic [BW-1:0] r_bcnt;
    logic          r_phase;

    // Blink phase: counts frames while blink is requested, toggles every
    // BLINK_FRAMES frames; dropping blink snaps straight back to ON.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bcnt  <= '0;
            r_phase <= PHASE_ON;
        end else if (!bus.blink) begin
            r_bcnt  <= '0;
            r_phase <= PHASE_ON;
        end else if (w_frame_end) begin
            if (r_bcnt == BW'(BLINK_FRAMES - 1)) begin
                r_bcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bcnt  <= r_bcnt + 1'b1;
            end
        end
    end

    // Gated with the live request so releasing blink restores the scan at once.
    assign w_blink_off = bus.blink & (r_phase == PHASE_OFF);
`else
    logic w_unused_blink;
    assign w_unused_blink = bus.blink;
    assign w_blink_off    = 1'b0;
`endif

    assign w_off = w_in_blank | w_blink_off;

    // Frame snapshot and registered display drive, one cycle behind (cnt, sel).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snap       <= '0;
            r_an         <= AN_OFF;
            r_seg        <= SEG_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_end;
            if (w_frame_end) begin
                r_snap <= bus.digits;
            end
            r_an  <= w_off ? AN_OFF : an_select(w_sel);
            r_seg <= ~r_snap[w_sel];
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_scanner
//  Description : Directed self-checking bench for seven_seg_scanner with
//                REFRESH_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seven_seg_scanner;
    import seven_seg_pkg::*;

    localparam int REFRESH_DIV  = 4;
    localparam int BLANK_CYC    = 1;
    localparam int BLINK_FRAMES = 2;

    // Hand-computed active-low segment patterns.
    localparam logic [6:0] S_BLANK = 7'h7F;  // ~SEG_BLANK
    localparam logic [6:0] S_ALL   = 7'h00;  // ~SEG_ALL
    localparam logic [6:0] S_D     = 7'h42;  // ~7'b0111101
    localparam logic [6:0] S_E     = 7'h30;  // ~7'b1001111
    localparam logic [6:0] S_A     = 7'h08;  // ~7'b1110111

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    int   pos;   // position within the 16-cycle frame of the state being shown

    seven_seg_if u_if ();

    seven_seg_scanner #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYC    (BLANK_CYC),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (pos %0d, t=%0t)", tag, obs, exp, pos, $time);
        end
    endtask

    // One clock: sample after the edge and compare against the slot pattern.
    task automatic step(input bit off, input logic [6:0] e3, input logic [6:0] e2,
                        input logic [6:0] e1, input logic [6:0] e0);
        logic [6:0] es;
        logic [3:0] ea;
        int         slot;
        int         c;
        @(posedge clk);
        #1;
        slot = pos / 4;
        c    = pos % 4;
        case (slot)
            0:       begin es = e3; ea = 4'h7; end
            1:       begin es = e2; ea = 4'hB; end
            2:       begin es = e1; ea = 4'hD; end
            default: begin es = e0; ea = 4'hE; end
        endcase
        if (off || c == 0) ea = 4'hF;
        chk("an",  {3'b000, u_if.an}, {3'b000, ea});
        chk("seg", u_if.seg, es);
        chk("frame_tick", {6'd0, u_if.frame_tick}, {6'd0, (pos == 15)});
        pos = (pos + 1) % 16;
    endtask

    task automatic run(input int n, input bit off, input logic [6:0] e3, input logic [6:0] e2,
                       input logic [6:0] e1, input logic [6:0] e0);
        for (int i = 0; i < n; i++) step(off, e3, e2, e1, e0);
    endtask

    initial begin
        clk          = 1'b0;
        reset_n      = 1'b0;
        checks       = 0;
        errors       = 0;
        pos          = 0;
        u_if.digits  = '0;
        u_if.blink   = 1'b0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_an",  {3'b000, u_if.an}, 7'h0F);
        chk("reset_seg", u_if.seg, S_BLANK);
        chk("reset_tick", {6'd0, u_if.frame_tick}, 7'd0);

        // First frame after release shows blank glyphs
        @(negedge clk);
        reset_n     = 1'b1;
        u_if.digits = {SEG_ALL, SEG_ALL, SEG_ALL, SEG_ALL};
        pos         = 0;
        run(16, 1'b0, S_BLANK, S_BLANK, S_BLANK, S_BLANK);

        // Second frame: all segments lit; load dEAd mid-frame for the next one
        run(4, 1'b0, S_ALL, S_ALL, S_ALL, S_ALL);
        u_if.digits = {GLYPH_D, GLYPH_E, GLYPH_A, GLYPH_D};
        run(12, 1'b0, S_ALL, S_ALL, S_ALL, S_ALL);

        // Third frame: dEAd, with a mid-frame change that must stay hidden
        run(8, 1'b0, S_D, S_E, S_A, S_D);
        u_if.digits = {SEG_ALL, SEG_ALL, SEG_ALL, SEG_ALL};
        run(8, 1'b0, S_D, S_E, S_A, S_D);

        // Fourth frame: the change becomes visible
        run(16, 1'b0, S_ALL, S_ALL, S_ALL, S_ALL);

        // Asynchronous reset while sel=1, cnt=2
        run(10, 1'b0, S_ALL, S_ALL, S_ALL, S_ALL);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_an",  {3'b000, u_if.an}, 7'h0F);
        chk("async_seg", u_if.seg, S_BLANK);
        chk("async_tick", {6'd0, u_if.frame_tick}, 7'd0);
        @(negedge clk);
        reset_n = 1'b1;
        pos     = 0;
        run(16, 1'b0, S_BLANK, S_BLANK, S_BLANK, S_BLANK);

`ifdef SEVSEG_BLINK_EN
        // Blink: two frames on, two frames off, then released mid off-phase
        u_if.blink = 1'b1;
        run(32, 1'b0, S_ALL, S_ALL, S_ALL, S_ALL);
        run(32, 1'b1, S_ALL, S_ALL, S_ALL, S_ALL);
        run(32, 1'b0, S_ALL, S_ALL, S_ALL, S_ALL);
        run(6,  1'b1, S_ALL, S_ALL, S_ALL, S_ALL);
        u_if.blink = 1'b0;
        run(26, 1'b0, S_ALL, S_ALL, S_ALL, S_ALL);
`else
        // Blink request has no effect without the feature
        u_if.blink = 1'b1;
        run(64, 1'b0, S_ALL, S_ALL, S_ALL, S_ALL);
        u_if.blink = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
